// File: rtl/cbus_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cbus_write_buffer
// Purpose  : Posted-write buffer between the cache CBus master port and the
//            memory port. Single-beat stores are acked immediately, queued and
//            drained in order. Everything else passes straight through once
//            the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module cbus_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    // request from the cache side
    input  logic        creq_valid_i,
    input  logic        creq_is_write_i,
    input  logic [2:0]  creq_size_i,
    input  logic [31:0] creq_addr_i,
    input  logic [3:0]  creq_strobe_i,
    input  logic [31:0] creq_data_i,
    input  logic [3:0]  creq_len_i,
    input  logic [1:0]  creq_burst_i,
    // response to the cache side
    output logic        cresp_ready_o,
    output logic        cresp_last_o,
    output logic [31:0] cresp_data_o,
    // request to memory
    output logic        oreq_valid_o,
    output logic        oreq_is_write_o,
    output logic [2:0]  oreq_size_o,
    output logic [31:0] oreq_addr_o,
    output logic [3:0]  oreq_strobe_o,
    output logic [31:0] oreq_data_o,
    output logic [3:0]  oreq_len_o,
    output logic [1:0]  oreq_burst_o,
    // response from memory
    input  logic        oresp_ready_i,
    input  logic        oresp_last_i,
    input  logic [31:0] oresp_data_i,
    // queue empty and no pass-through in progress
    output logic        empty_o
);

    localparam int         AW              = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C        = (AW + 1)'(DEPTH);
    localparam logic [3:0] MLEN1           = 4'd0;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [AW:0]     count_q, count_d;

    logic [31:0]     addr_mem_q   [DEPTH];
    logic [31:0]     data_mem_q   [DEPTH];
    logic [3:0]      strobe_mem_q [DEPTH];
    logic [2:0]      size_mem_q   [DEPTH];

    logic bufferable;
    logic draining;
    logic push;
    logic pop;

    assign bufferable = creq_valid_i && creq_is_write_i && (creq_len_i == MLEN1);
    assign draining   = (state_q == IDLE) && (count_q != '0);
    // No bypass of a same-cycle pop: a full queue refuses regardless of oresp.
    assign push       = bufferable && (count_q < DEPTH_C) && (state_q == IDLE);
    assign pop        = draining && oresp_last_i;
    assign empty_o    = (count_q == '0) && (state_q == IDLE);

    // Output steering: pass-through in PASS, otherwise drain head and store ack
    always_comb begin
        cresp_ready_o   = 1'b0;
        cresp_last_o    = 1'b0;
        cresp_data_o    = '0;
        oreq_valid_o    = 1'b0;
        oreq_is_write_o = 1'b0;
        oreq_size_o     = '0;
        oreq_addr_o     = '0;
        oreq_strobe_o   = '0;
        oreq_data_o     = '0;
        oreq_len_o      = '0;
        oreq_burst_o    = '0;
        if (state_q == PASS) begin
            oreq_valid_o    = creq_valid_i;
            oreq_is_write_o = creq_is_write_i;
            oreq_size_o     = creq_size_i;
            oreq_addr_o     = creq_addr_i;
            oreq_strobe_o   = creq_strobe_i;
            oreq_data_o     = creq_data_i;
            oreq_len_o      = creq_len_i;
            oreq_burst_o    = creq_burst_i;
            cresp_ready_o   = oresp_ready_i;
            cresp_last_o    = oresp_last_i;
            cresp_data_o    = oresp_data_i;
        end else begin
            if (draining) begin
                oreq_valid_o    = 1'b1;
                oreq_is_write_o = 1'b1;
                oreq_size_o     = size_mem_q[head_q];
                oreq_addr_o     = addr_mem_q[head_q];
                oreq_strobe_o   = strobe_mem_q[head_q];
                oreq_data_o     = data_mem_q[head_q];
                oreq_len_o      = MLEN1;
                oreq_burst_o    = AXI_BURST_FIXED;
            end
            if (push) begin
                cresp_ready_o = 1'b1;
                cresp_last_o  = 1'b1;
            end
        end
    end

    // Next-state for pointers, occupancy and the IDLE/PASS state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        case (state_q)
            IDLE: begin
                if (creq_valid_i && !bufferable && (count_q == '0)) begin
                    state_d = PASS;
                end
            end
            PASS: begin
                if (creq_valid_i && oresp_last_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage; contents are qualified by count so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[tail_q]   <= creq_addr_i;
            data_mem_q[tail_q]   <= creq_data_i;
            strobe_mem_q[tail_q] <= creq_strobe_i;
            size_mem_q[tail_q]   <= creq_size_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cbus_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cbus_write_buffer
// Purpose  : Directed self-checking bench for cbus_write_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cbus_write_buffer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        creq_valid, creq_is_write;
    logic [2:0]  creq_size;
    logic [31:0] creq_addr, creq_data;
    logic [3:0]  creq_strobe, creq_len;
    logic [1:0]  creq_burst;
    logic        cresp_ready, cresp_last;
    logic [31:0] cresp_data;
    logic        oreq_valid, oreq_is_write;
    logic [2:0]  oreq_size;
    logic [31:0] oreq_addr, oreq_data;
    logic [3:0]  oreq_strobe, oreq_len;
    logic [1:0]  oreq_burst;
    logic        oresp_ready, oresp_last;
    logic [31:0] oresp_data;
    logic        empty;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cbus_write_buffer #(.DEPTH(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .creq_valid_i    (creq_valid),
        .creq_is_write_i (creq_is_write),
        .creq_size_i     (creq_size),
        .creq_addr_i     (creq_addr),
        .creq_strobe_i   (creq_strobe),
        .creq_data_i     (creq_data),
        .creq_len_i      (creq_len),
        .creq_burst_i    (creq_burst),
        .cresp_ready_o   (cresp_ready),
        .cresp_last_o    (cresp_last),
        .cresp_data_o    (cresp_data),
        .oreq_valid_o    (oreq_valid),
        .oreq_is_write_o (oreq_is_write),
        .oreq_size_o     (oreq_size),
        .oreq_addr_o     (oreq_addr),
        .oreq_strobe_o   (oreq_strobe),
        .oreq_data_o     (oreq_data),
        .oreq_len_o      (oreq_len),
        .oreq_burst_o    (oreq_burst),
        .oresp_ready_i   (oresp_ready),
        .oresp_last_i    (oresp_last),
        .oresp_data_i    (oresp_data),
        .empty_o         (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_req();
        creq_valid = 0; creq_is_write = 0; creq_size = 0; creq_addr = 0;
        creq_data = 0; creq_strobe = 0; creq_len = 0; creq_burst = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        creq_valid = 1; creq_is_write = 1; creq_size = 3'd2; creq_addr = a;
        creq_data = d; creq_strobe = 4'hF; creq_len = 4'd0; creq_burst = 2'b01;
    endtask

    initial begin
        resetn = 0; idle_req();
        oresp_ready = 0; oresp_last = 0; oresp_data = 0;
        tick(); tick();
        resetn = 1;
        settle();
        // ---------------- reset state ----------------
        chk("rst_oreq_valid", {31'b0, oreq_valid}, 32'd0);
        chk("rst_cresp_ready", {31'b0, cresp_ready}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);

        // ---------------- single store ----------------
        store(32'h1FD0_0000, 32'hDEAD_BEEF);
        settle();
        chk("ss_ack_ready", {31'b0, cresp_ready}, 32'd1);
        chk("ss_ack_last", {31'b0, cresp_last}, 32'd1);
        chk("ss_ack_data", cresp_data, 32'd0);
        tick(); idle_req(); settle();
        chk("ss_oreq_valid", {31'b0, oreq_valid}, 32'd1);
        chk("ss_oreq_addr", oreq_addr, 32'h1FD0_0000);
        chk("ss_oreq_data", oreq_data, 32'hDEAD_BEEF);
        chk("ss_oreq_strobe", {28'b0, oreq_strobe}, 32'hF);
        chk("ss_oreq_wr_len_burst", {25'b0, oreq_is_write, oreq_len, oreq_burst}, 32'h40);
        chk("ss_oreq_size", {29'b0, oreq_size}, 32'd2);
        chk("ss_not_empty", {31'b0, empty}, 32'd0);
        tick(); tick();
        chk("ss_stable_addr", oreq_addr, 32'h1FD0_0000);
        oresp_ready = 1; oresp_last = 1;
        tick(); oresp_ready = 0; oresp_last = 0; settle();
        chk("ss_done_valid", {31'b0, oreq_valid}, 32'd0);
        chk("ss_done_empty", {31'b0, empty}, 32'd1);

        // ---------------- full queue ----------------
        for (int i = 0; i < 4; i++) begin
            store(32'(i * 4), 32'h100 + 32'(i));
            settle();
            chk($sformatf("fq_ack%0d", i), {31'b0, cresp_ready}, 32'd1);
            tick();
        end
        store(32'h10, 32'h104);
        settle();
        chk("fq_full_hold", {31'b0, cresp_ready}, 32'd0);
        tick();
        chk("fq_full_hold2", {31'b0, cresp_ready}, 32'd0);
        chk("fq_head0", oreq_addr, 32'h0);
        oresp_ready = 1; oresp_last = 1;
        settle();
        chk("fq_no_bypass", {31'b0, cresp_ready}, 32'd0);
        tick(); oresp_ready = 0; oresp_last = 0; settle();
        chk("fq_ack5_after_pop", {31'b0, cresp_ready}, 32'd1);
        chk("fq_head1", oreq_addr, 32'h4);
        tick(); idle_req();
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk($sformatf("fq_order%0d", k), oreq_addr, 32'(k * 4));
            chk($sformatf("fq_valid%0d", k), {31'b0, oreq_valid}, 32'd1);
            oresp_ready = 1; oresp_last = 1;
            tick(); oresp_ready = 0; oresp_last = 0;
        end
        settle();
        chk("fq_empty", {31'b0, empty}, 32'd1);

        // ---------------- simultaneous push and pop (pointers wrap) ----------------
        store(32'h100, 32'hA); tick();
        store(32'h104, 32'hB); tick();
        store(32'h108, 32'hC); oresp_ready = 1; oresp_last = 1;
        settle();
        chk("sp_ack", {31'b0, cresp_ready}, 32'd1);
        tick(); idle_req(); oresp_ready = 0; oresp_last = 0; settle();
        chk("sp_head_b", oreq_addr, 32'h104);
        // count must still be 2: two more stores fit, a third does not
        store(32'h10C, 32'hD); settle();
        chk("sp_room1", {31'b0, cresp_ready}, 32'd1);
        tick();
        store(32'h110, 32'hE); settle();
        chk("sp_room2", {31'b0, cresp_ready}, 32'd1);
        tick();
        store(32'h114, 32'hF); settle();
        chk("sp_full", {31'b0, cresp_ready}, 32'd0);
        idle_req();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("sp_order%0d", k), oreq_addr, 32'h104 + 32'(k * 4));
            oresp_ready = 1; oresp_last = 1;
            tick(); oresp_ready = 0; oresp_last = 0;
        end
        settle();
        chk("sp_empty", {31'b0, empty}, 32'd1);

        // ---------------- read ordering ----------------
        store(32'h200, 32'h1); tick();
        store(32'h204, 32'h2); tick();
        creq_valid = 1; creq_is_write = 0; creq_addr = 32'h300; creq_len = 4'd7;
        creq_burst = 2'b01; creq_size = 3'd2; creq_strobe = 0; creq_data = 0;
        settle();
        chk("rd_stall0", {29'b0, cresp_ready, cresp_last, |cresp_data}, 32'd0);
        chk("rd_w0", oreq_addr, 32'h200);
        oresp_ready = 1; oresp_last = 1;
        tick(); oresp_ready = 0; oresp_last = 0; settle();
        chk("rd_w1", oreq_addr, 32'h204);
        chk("rd_stall1", {31'b0, cresp_ready}, 32'd0);
        oresp_ready = 1; oresp_last = 1;
        tick(); oresp_ready = 0; oresp_last = 0; settle();
        chk("rd_gap_valid", {31'b0, oreq_valid}, 32'd0);
        tick();
        chk("rd_pass_valid", {31'b0, oreq_valid}, 32'd1);
        chk("rd_pass_addr", oreq_addr, 32'h300);
        chk("rd_pass_wr_len", {27'b0, oreq_is_write, oreq_len}, 32'h7);
        chk("rd_pass_empty", {31'b0, empty}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            oresp_ready = 1; oresp_last = (k == 7); oresp_data = 32'hA0 + 32'(k);
            settle();
            chk($sformatf("rd_beat%0d_data", k), cresp_data, 32'hA0 + 32'(k));
            chk($sformatf("rd_beat%0d_rl", k), {30'b0, cresp_ready, cresp_last},
                (k == 7) ? 32'd3 : 32'd2);
            tick();
        end
        idle_req(); oresp_ready = 0; oresp_last = 0; oresp_data = 0; settle();
        chk("rd_back_idle", {31'b0, empty}, 32'd1);

        // ---------------- write-back burst ----------------
        creq_valid = 1; creq_is_write = 1; creq_addr = 32'h400; creq_len = 4'd15;
        creq_burst = 2'b01; creq_size = 3'd2; creq_strobe = 4'hF; creq_data = 32'h0;
        settle();
        chk("wb_idle_cycle", {31'b0, cresp_ready}, 32'd0);
        tick();
        for (int k = 0; k < 16; k++) begin
            creq_data = 32'hB00 + 32'(k);
            oresp_ready = 1; oresp_last = (k == 15);
            settle();
            chk($sformatf("wb_beat%0d_data", k), oreq_data, 32'hB00 + 32'(k));
            chk($sformatf("wb_beat%0d_rl", k), {30'b0, cresp_ready, cresp_last},
                (k == 15) ? 32'd3 : 32'd2);
            tick();
        end
        idle_req(); oresp_ready = 0; oresp_last = 0; settle();
        chk("wb_back_idle", {30'b0, empty, oreq_valid}, 32'd2);

        // ---------------- reset mid-drain ----------------
        store(32'h500, 32'h55); tick(); idle_req(); settle();
        chk("rm_draining", {31'b0, oreq_valid}, 32'd1);
        resetn = 0;
        tick(); resetn = 1; settle();
        chk("rm_valid", {31'b0, oreq_valid}, 32'd0);
        chk("rm_empty", {31'b0, empty}, 32'd1);
        store(32'h1FD0_0000, 32'hDEAD_BEEF); settle();
        chk("rm_ack", {31'b0, cresp_last}, 32'd1);
        tick(); idle_req(); settle();
        chk("rm_oreq_addr", oreq_addr, 32'h1FD0_0000);
        chk("rm_oreq_data", oreq_data, 32'hDEAD_BEEF);
        oresp_ready = 1; oresp_last = 1;
        tick(); oresp_ready = 0; oresp_last = 0; settle();
        chk("rm_final_empty", {31'b0, empty}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
